// File: rtl/ycr1_mul_pkg.sv
// Shared definitions for the RV32M multiplier path: command encoding and datapath widths.
package ycr1_mul_pkg;

  localparam int YCR1_MUL_OPW  = 33;
  localparam int YCR1_MUL_RESW = 64;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } type_ycr1_mul_cmd_e;

endpackage

// File: rtl/ycr1_pipe_mul_if.sv
// Issue/return stage between the EXU and the iterative 33x33 multiplier, with a
// one-entry product cache so a MULH/MUL pair on identical operands costs one multiply.
module ycr1_pipe_mul_if
  import ycr1_mul_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    mul_req_i,
  input  logic [1:0]              mul_cmd_i,
  input  logic [31:0]             mul_op1_i,
  input  logic [31:0]             mul_op2_i,
  input  logic                    flush_i,
  output logic                    mul_busy_o,
  output logic [31:0]             mul_res_o,
  output logic                    mul_res_rdy_o,
  output logic [YCR1_MUL_OPW-1:0] mul_din1_o,
  output logic [YCR1_MUL_OPW-1:0] mul_din2_o,
  output logic                    mul_valid_o,
  input  logic [31:0]             mul_hig_i,
  input  logic [31:0]             mul_low_i,
  input  logic                    mul_rdy_i,
  output logic                    mul_done_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_e;

  state_e                     state_reg;
  type_ycr1_mul_cmd_e         cmd_reg;
  logic [YCR1_MUL_OPW-1:0]    din1_reg;
  logic [YCR1_MUL_OPW-1:0]    din2_reg;
  logic [YCR1_MUL_RESW-1:0]   prod_reg;
  logic [2*YCR1_MUL_OPW-1:0]  tag_reg;
  logic                       cache_vld_reg;
  logic [31:0]                res_reg;
  logic                       valid_reg;
  logic                       done_reg;

  type_ycr1_mul_cmd_e         cmd_new;
  logic [YCR1_MUL_OPW-1:0]    din1_new;
  logic [YCR1_MUL_OPW-1:0]    din2_new;
  logic                       cache_hit;
  logic [YCR1_MUL_RESW-1:0]   prod_new;

  function automatic logic [31:0] sel_res(input logic [YCR1_MUL_RESW-1:0] prod,
                                          input type_ycr1_mul_cmd_e cmd);
    return (cmd == MUL) ? prod[31:0] : prod[63:32];
  endfunction

  // op1 is signed for everything but MULHU; op2 only for MUL/MULH
  assign cmd_new   = type_ycr1_mul_cmd_e'(mul_cmd_i);
  assign din1_new  = {mul_op1_i[31] & (cmd_new != MULHU), mul_op1_i};
  assign din2_new  = {mul_op2_i[31] & ((cmd_new == MUL) | (cmd_new == MULH)), mul_op2_i};
  assign cache_hit = CACHE_EN && cache_vld_reg && ({din1_new, din2_new} == tag_reg);
  assign prod_new  = {mul_hig_i, mul_low_i};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cmd_reg       <= MUL;
      din1_reg      <= '0;
      din2_reg      <= '0;
      prod_reg      <= '0;
      tag_reg       <= '0;
      cache_vld_reg <= 1'b0;
      res_reg       <= '0;
      valid_reg     <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mul_req_i && !flush_i) begin
            cmd_reg  <= cmd_new;
            din1_reg <= din1_new;
            din2_reg <= din2_new;
            if (cache_hit) begin
              res_reg   <= sel_res(prod_reg, cmd_new);
              state_reg <= RESP;
            end else begin
              valid_reg <= 1'b1;
              state_reg <= ISSUE;
            end
          end
        end
        ISSUE: state_reg <= flush_i ? DRAIN : WAIT;
        WAIT: begin
          if (mul_rdy_i) begin
            done_reg <= 1'b1;
            if (flush_i) begin
              state_reg <= IDLE;
            end else begin
              prod_reg      <= prod_new;
              tag_reg       <= {din1_reg, din2_reg};
              cache_vld_reg <= 1'b1;
              res_reg       <= sel_res(prod_new, cmd_reg);
              state_reg     <= RESP;
            end
          end else if (flush_i) begin
            state_reg <= DRAIN;
          end
        end
        RESP: state_reg <= IDLE;
        // A killed multiply still has to run to completion and be released.
        DRAIN: begin
          if (mul_rdy_i) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mul_busy_o    = (state_reg != IDLE);
  assign mul_res_rdy_o = (state_reg == RESP) && !flush_i;
  assign mul_res_o     = res_reg;
  assign mul_din1_o    = din1_reg;
  assign mul_din2_o    = din2_reg;
  assign mul_valid_o   = valid_reg;
  assign mul_done_o    = done_reg;

endmodule

// File: tb/tb_ycr1_pipe_mul_if.sv
// Directed bench for ycr1_pipe_mul_if with a small behavioural multiplier beside it.
module tb_ycr1_pipe_mul_if;
  import ycr1_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mul_req_i = 1'b0;
  logic [1:0]  mul_cmd_i = 2'b00;
  logic [31:0] mul_op1_i = '0;
  logic [31:0] mul_op2_i = '0;
  logic        flush_i = 1'b0;
  logic        mul_busy_o;
  logic [31:0] mul_res_o;
  logic        mul_res_rdy_o;
  logic [32:0] mul_din1_o;
  logic [32:0] mul_din2_o;
  logic        mul_valid_o;
  logic [31:0] mul_hig_i;
  logic [31:0] mul_low_i;
  logic        mul_rdy_i;
  logic        mul_done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ycr1_pipe_mul_if #(.CACHE_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .mul_req_i(mul_req_i), .mul_cmd_i(mul_cmd_i),
    .mul_op1_i(mul_op1_i), .mul_op2_i(mul_op2_i), .flush_i(flush_i),
    .mul_busy_o(mul_busy_o), .mul_res_o(mul_res_o), .mul_res_rdy_o(mul_res_rdy_o),
    .mul_din1_o(mul_din1_o), .mul_din2_o(mul_din2_o), .mul_valid_o(mul_valid_o),
    .mul_hig_i(mul_hig_i), .mul_low_i(mul_low_i), .mul_rdy_i(mul_rdy_i),
    .mul_done_o(mul_done_o)
  );

  // Behavioural multiplier: fixed latency, product taken from the held operands.
  logic signed [65:0] model_prod;
  int   m_cnt;
  logic m_busy;
  always_comb model_prod = 66'($signed(mul_din1_o)) * 66'($signed(mul_din2_o));

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_busy <= 1'b0; m_cnt <= 0; mul_rdy_i <= 1'b0; mul_hig_i <= '0; mul_low_i <= '0;
    end else begin
      mul_rdy_i <= 1'b0;
      if (mul_valid_o) begin
        m_busy <= 1'b1; m_cnt <= 3;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0; mul_rdy_i <= 1'b1;
          {mul_hig_i, mul_low_i} <= model_prod[63:0];
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  int vcnt = 0;
  int dcnt = 0;
  always @(posedge clk) begin
    vcnt <= vcnt + int'(mul_valid_o);
    dcnt <= dcnt + int'(mul_done_o);
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int nv,
                         output int nd, output logic [32:0] d1, output logic [32:0] d2,
                         output bit got);
    int v0, d0;
    @(negedge clk);
    v0 = vcnt; d0 = dcnt;
    mul_req_i = 1'b1; mul_cmd_i = c; mul_op1_i = a; mul_op2_i = b;
    @(negedge clk);
    mul_req_i = 1'b0;
    d1 = mul_din1_o; d2 = mul_din2_o;
    lat = 1; got = 1'b0; res = '0;
    while (lat < 50) begin
      if (mul_res_rdy_o) begin
        got = 1'b1; res = mul_res_o;
        break;
      end
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    nv = vcnt - v0; nd = dcnt - d0;
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    logic [32:0] din1;
    logic [32:0] din2;
    bit          hit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] res;
    logic [32:0] d1, d2;
    int lat, nv, nd, v0, d0, k;
    bit got, saw_rdy, saw_done, busy_at_rdy, busy_at_done;

    vecs[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 33'h1FFFFFFFF, 33'h000000002, 1'b0};
    vecs[1] = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 33'h0FFFFFFFF, 33'h000000002, 1'b0};
    vecs[2] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 33'h180000000, 33'h180000000, 1'b0};
    vecs[3] = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 33'h180000000, 33'h180000000, 1'b1};
    vecs[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1FFFFFFFF, 33'h0FFFFFFFF, 1'b0};
    vecs[5] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33'h000000007, 33'h1FFFFFFFD, 1'b0};
    vecs[6] = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 33'h000000007, 33'h1FFFFFFFD, 1'b1};
    vecs[7] = '{2'b11, 32'h00000007, 32'hFFFFFFFD, 32'h00000006, 33'h000000007, 33'h0FFFFFFFD, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_busy", 66'(mul_busy_o), 66'(0));
    chk("rst_outs", {mul_res_rdy_o, mul_valid_o, mul_done_o, mul_res_o}, 66'(0));
    chk("rst_din", {mul_din1_o, mul_din2_o}, 66'(0));
    rstn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_req(vecs[i].cmd, vecs[i].op1, vecs[i].op2, res, lat, nv, nd, d1, d2, got);
      $display("vec %0d cmd=%0d op1=%h op2=%h res=%h lat=%0d valid=%0d done=%0d",
               i, vecs[i].cmd, vecs[i].op1, vecs[i].op2, res, lat, nv, nd);
      chk($sformatf("v%0d_got", i), 66'(got), 66'(1));
      chk($sformatf("v%0d_res", i), 66'(res), 66'(vecs[i].res));
      chk($sformatf("v%0d_din1", i), 66'(d1), 66'(vecs[i].din1));
      chk($sformatf("v%0d_din2", i), 66'(d2), 66'(vecs[i].din2));
      chk($sformatf("v%0d_valid", i), 66'(nv), vecs[i].hit ? 66'(0) : 66'(1));
      chk($sformatf("v%0d_done", i), 66'(nd), vecs[i].hit ? 66'(0) : 66'(1));
      if (vecs[i].hit) chk($sformatf("v%0d_hitlat", i), 66'(lat), 66'(1));
    end

    // Flush a MUL 5*6 while it is waiting on the multiplier.
    @(negedge clk);
    v0 = vcnt; d0 = dcnt;
    mul_req_i = 1'b1; mul_cmd_i = 2'b00; mul_op1_i = 32'd5; mul_op2_i = 32'd6;
    @(negedge clk);
    mul_req_i = 1'b0;
    k = 1; saw_rdy = 0; saw_done = 0; busy_at_rdy = 0; busy_at_done = 1;
    while (k < 40 && !saw_done) begin
      if (mul_res_rdy_o) saw_rdy = 1;
      if (mul_rdy_i) busy_at_rdy = mul_busy_o;
      if (mul_done_o) begin saw_done = 1; busy_at_done = mul_busy_o; end
      if (k == 2) flush_i = 1'b1;
      if (k == 3) flush_i = 1'b0;
      if (!saw_done) begin
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    $display("flush: done_seen=%0d res_rdy_seen=%0d cycles=%0d", saw_done, saw_rdy, k);
    chk("flush_done", 66'(saw_done), 66'(1));
    chk("flush_no_rdy", 66'(saw_rdy), 66'(0));
    chk("flush_busy_rdy", 66'(busy_at_rdy), 66'(1));
    chk("flush_busy_done", 66'(busy_at_done), 66'(0));
    chk("flush_valid", 66'(vcnt - v0), 66'(1));
    chk("flush_dcnt", 66'(dcnt - d0), 66'(1));

    run_req(2'b11, 32'h00000007, 32'hFFFFFFFD, res, lat, nv, nd, d1, d2, got);
    $display("post-flush cached MULHU res=%h lat=%0d valid=%0d", res, lat, nv);
    chk("pf_hit_res", 66'(res), 66'(32'h6));
    chk("pf_hit_valid", 66'(nv), 66'(0));
    chk("pf_hit_lat", 66'(lat), 66'(1));
    run_req(2'b00, 32'd5, 32'd6, res, lat, nv, nd, d1, d2, got);
    $display("post-flush MUL 5*6 res=%h valid=%0d done=%0d", res, nv, nd);
    chk("pf_mul_res", 66'(res), 66'(30));
    chk("pf_mul_valid", 66'(nv), 66'(1));
    chk("pf_mul_got", 66'(got), 66'(1));

    // Prime the cache, then reset during WAIT of another request.
    run_req(2'b01, 32'h80000000, 32'h80000000, res, lat, nv, nd, d1, d2, got);
    $display("prime MULH res=%h valid=%0d", res, nv);
    chk("prime_res", 66'(res), 66'(32'h40000000));
    @(negedge clk);
    mul_req_i = 1'b1; mul_cmd_i = 2'b00; mul_op1_i = 32'd3; mul_op2_i = 32'd4;
    @(negedge clk);
    mul_req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", 66'(mul_busy_o), 66'(1));
    rstn = 1'b0;
    #1;
    $display("async reset: busy=%0d res=%h din1=%h din2=%h", mul_busy_o, mul_res_o, mul_din1_o, mul_din2_o);
    chk("arst_busy", 66'(mul_busy_o), 66'(0));
    chk("arst_outs", {mul_res_rdy_o, mul_valid_o, mul_done_o, mul_res_o}, 66'(0));
    chk("arst_din", {mul_din1_o, mul_din2_o}, 66'(0));
    @(negedge clk);
    rstn = 1'b1;
    run_req(2'b01, 32'h80000000, 32'h80000000, res, lat, nv, nd, d1, d2, got);
    $display("post-reset MULH res=%h lat=%0d valid=%0d done=%0d", res, lat, nv, nd);
    chk("prst_res", 66'(res), 66'(32'h40000000));
    chk("prst_miss_valid", 66'(nv), 66'(1));
    chk("prst_miss_done", 66'(nd), 66'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
